// File: rtl/cond_branch_unit.sv
// Branch-condition stage: full compare set, hardware call/return stack and a
// maskable interrupt pending/service controller behind a valid/ready handshake.
module cond_branch_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int STACK_DEPTH = 8,
    parameter int NUM_INT     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 op,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [ADDR_W-1:0]          pc_next,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_taken,
    output logic                       out_ret,
    output logic [ADDR_W-1:0]          out_target,
    output logic                       out_err,
    input  logic [NUM_INT-1:0]         irq,
    input  logic                       mask_we,
    input  logic [NUM_INT-1:0]         mask_wdata,
    output logic                       int_req,
    output logic [$clog2(NUM_INT)-1:0] int_id,
    input  logic                       int_ack,
    output logic                       in_service
);

    localparam int ID_W  = $clog2(NUM_INT);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} int_state_t;

    int_state_t          state;
    logic [SP_W-1:0]     sp;
    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];
    logic [NUM_INT-1:0]  pending;
    logic [NUM_INT-1:0]  mask;
    logic [NUM_INT-1:0]  masked;
    logic [NUM_INT-1:0]  soft_set;
    logic [NUM_INT-1:0]  ack_clr;
    logic [ID_W-1:0]     lowest_id;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    top_idx;
    logic                accept;
    logic                stack_full;
    logic                stack_empty;
    logic                b_in_range;
    logic                int_clear;
    logic                d_taken;
    logic                d_ret;
    logic                d_err;
    logic [ADDR_W-1:0]   d_target;
    logic                do_push;
    logic                do_pop;
    logic                iret_ok;

    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = sp[IDX_W-1:0];
    assign top_idx     = push_idx - IDX_W'(1);
    assign b_in_range  = ({1'b0, b} < (DATA_W+1)'(NUM_INT));
    assign masked      = pending & mask;
    assign int_id      = lowest_id;
    assign int_clear   = (state == REQ) && int_ack && (masked != '0);

    // Side effects (push/pop/iret/soft int) only fire for an accepted op.
    always_comb begin
        d_taken  = 1'b0;
        d_ret    = 1'b0;
        d_err    = 1'b0;
        d_target = '0;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        iret_ok  = 1'b0;
        soft_set = '0;
        case (op)
            4'h0: d_taken = 1'b1;
            4'h1: d_taken = (a == b);
            4'h2: d_taken = (a != b);
            4'h3: d_taken = (a > b);
            4'h4: d_taken = (a < b);
            4'h5: d_taken = (a >= b);
            4'h6: d_taken = (a <= b);
            4'h7: d_taken = 1'b0;
            4'h8: begin
                if (!stack_empty) begin
                    d_taken  = 1'b1;
                    d_ret    = 1'b1;
                    d_target = stack_mem[top_idx];
                    do_pop   = accept;
                end else begin
                    d_err = 1'b1;
                end
            end
            4'h9: begin
                if (!stack_full) begin
                    d_taken = 1'b1;
                    do_push = accept;
                end else begin
                    d_err = 1'b1;
                end
            end
            4'hA: begin
                if (in_service) begin
                    d_taken = 1'b1;
                    iret_ok = accept;
                end else begin
                    d_err = 1'b1;
                end
            end
            4'hB: begin
                if (b_in_range) begin
                    d_taken = 1'b1;
                    soft_set[b[ID_W-1:0]] = accept;
                end else begin
                    d_err = 1'b1;
                end
            end
            4'hC: d_taken = ($signed(a) >  $signed(b));
            4'hD: d_taken = ($signed(a) <  $signed(b));
            4'hE: d_taken = ($signed(a) >= $signed(b));
            4'hF: d_taken = ($signed(a) <= $signed(b));
            default: ;
        endcase
    end

    // Lowest-index enabled pending line wins.
    always_comb begin
        lowest_id = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (masked[i]) lowest_id = ID_W'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (int_clear) ack_clr[lowest_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_taken  <= 1'b0;
            out_ret    <= 1'b0;
            out_target <= '0;
            out_err    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_taken  <= d_taken;
            out_ret    <= d_ret;
            out_target <= d_target;
            out_err    <= d_err;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) stack_mem[push_idx] <= pc_next;
    end

    // Set beats the ack clear so a line re-raised in the ack cycle stays pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending    <= '0;
            mask       <= '1;
            state      <= IDLE;
            int_req    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            pending <= (pending & ~ack_clr) | irq | soft_set;
            if (mask_we) mask <= mask_wdata;
            case (state)
                IDLE: begin
                    if (masked != '0) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (masked == '0) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end else if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (iret_ok) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: compare table, stack, backpressure,
// interrupt sequences and a randomized run against a queue-based reference model.
module tb_cond_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc_next;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic        out_ret;
    logic [31:0] out_target;
    logic        out_err;
    logic [31:0] irq;
    logic        mask_we;
    logic [31:0] mask_wdata;
    logic        int_req;
    logic [4:0]  int_id;
    logic        int_ack;
    logic        in_service;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] mstack[$];
    logic        exp_valid;
    logic        exp_taken;
    logic        exp_ret;
    logic [31:0] exp_target;
    logic        exp_err;

    cond_branch_unit #(
        .DATA_W(32), .ADDR_W(32), .STACK_DEPTH(8), .NUM_INT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .pc_next(pc_next),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_ret(out_ret),
        .out_target(out_target), .out_err(out_err),
        .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .int_req(int_req), .int_id(int_id), .int_ack(int_ack),
        .in_service(in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkDecision(input string name, input logic taken, input logic ret,
                                 input logic [31:0] target, input logic err);
        checkOutput({name, " valid"},  64'(out_valid),  64'(1));
        checkOutput({name, " taken"},  64'(out_taken),  64'(taken));
        checkOutput({name, " ret"},    64'(out_ret),    64'(ret));
        checkOutput({name, " target"}, 64'(out_target), 64'(target));
        checkOutput({name, " err"},    64'(out_err),    64'(err));
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic [3:0] t_op, input logic [31:0] t_a,
                                 input logic [31:0] t_b, input logic [31:0] t_pc);
        in_valid  = 1'b1;
        op        = t_op;
        a         = t_a;
        b         = t_b;
        pc_next   = t_pc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        irq       = '0;
        int_ack   = 1'b0;
        mask_we   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mstack.delete();
    endtask

    task automatic addVec(input string n, input logic [3:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic t);
        vec_t v;
        v.name = n; v.op = o; v.a = va; v.b = vb; v.exp_taken = t;
        vecs.push_back(v);
    endtask

    // Reference decision: stack as a bounded queue, compares as plain int arithmetic.
    task automatic modelDecide(input logic [3:0] m_op, input logic [31:0] m_a,
                               input logic [31:0] m_b, input logic [31:0] m_pc);
        int sa;
        int sb;
        sa = m_a;
        sb = m_b;
        exp_taken  = 1'b0;
        exp_ret    = 1'b0;
        exp_target = '0;
        exp_err    = 1'b0;
        case (m_op)
            4'h0: exp_taken = 1'b1;
            4'h1: exp_taken = (m_a == m_b);
            4'h2: exp_taken = (m_a != m_b);
            4'h3: exp_taken = (m_a > m_b);
            4'h4: exp_taken = (m_a < m_b);
            4'h5: exp_taken = (m_a >= m_b);
            4'h6: exp_taken = (m_a <= m_b);
            4'h7: exp_taken = 1'b0;
            4'h8: begin
                if (mstack.size() > 0) begin
                    exp_taken  = 1'b1;
                    exp_ret    = 1'b1;
                    exp_target = mstack.pop_back();
                end else exp_err = 1'b1;
            end
            4'h9: begin
                if (mstack.size() < 8) begin
                    exp_taken = 1'b1;
                    mstack.push_back(m_pc);
                end else exp_err = 1'b1;
            end
            4'hA: exp_err = 1'b1;
            4'hB: begin
                if (m_b < 32) exp_taken = 1'b1;
                else exp_err = 1'b1;
            end
            4'hC: exp_taken = (sa > sb);
            4'hD: exp_taken = (sa < sb);
            4'hE: exp_taken = (sa >= sb);
            default: exp_taken = (sa <= sb);
        endcase
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; pc_next = '0;
        out_ready = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0;

        addVec("sweep op3", 4'h3, 32'hFFFFFFFF, 32'h1, 1'b1);
        addVec("sweep opC", 4'hC, 32'hFFFFFFFF, 32'h1, 1'b0);
        addVec("sweep op4", 4'h4, 32'hFFFFFFFF, 32'h1, 1'b0);
        addVec("sweep opD", 4'hD, 32'hFFFFFFFF, 32'h1, 1'b1);
        addVec("sweep op1", 4'h1, 32'hFFFFFFFF, 32'h1, 1'b0);
        addVec("sweep op2", 4'h2, 32'hFFFFFFFF, 32'h1, 1'b1);
        addVec("eq op1",    4'h1, 32'h5, 32'h5, 1'b1);
        addVec("eq op5",    4'h5, 32'h5, 32'h5, 1'b1);
        addVec("eq op6",    4'h6, 32'h5, 32'h5, 1'b1);
        addVec("eq opE",    4'hE, 32'h5, 32'h5, 1'b1);
        addVec("eq opF",    4'hF, 32'h5, 32'h5, 1'b1);
        addVec("eq op3",    4'h3, 32'h5, 32'h5, 1'b0);
        addVec("min op3",   4'h3, 32'h80000000, 32'h7FFFFFFF, 1'b1);
        addVec("min opC",   4'hC, 32'h80000000, 32'h7FFFFFFF, 1'b0);
        addVec("min opD",   4'hD, 32'h80000000, 32'h7FFFFFFF, 1'b1);
        addVec("min op6",   4'h6, 32'h80000000, 32'h7FFFFFFF, 1'b0);
        addVec("min opF",   4'hF, 32'h80000000, 32'h7FFFFFFF, 1'b1);
        addVec("always",    4'h0, 32'h0, 32'h0, 1'b1);
        addVec("never",     4'h7, 32'h0, 32'h0, 1'b0);

        doReset();
        checkOutput("reset out_valid",  64'(out_valid),  64'(0));
        checkOutput("reset out_taken",  64'(out_taken),  64'(0));
        checkOutput("reset out_ret",    64'(out_ret),    64'(0));
        checkOutput("reset out_target", 64'(out_target), 64'(0));
        checkOutput("reset out_err",    64'(out_err),    64'(0));
        checkOutput("reset int_req",    64'(int_req),    64'(0));
        checkOutput("reset in_service", 64'(in_service), 64'(0));
        checkOutput("reset in_ready",   64'(in_ready),   64'(1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 32'h0);
            checkDecision(vecs[i].name, vecs[i].exp_taken, 1'b0, 32'h0, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'h9, 32'h0, 32'h0, 32'h100 + i);
            checkDecision("call", 1'b1, 1'b0, 32'h0, 1'b0);
        end
        applyStimulus(4'h9, 32'h0, 32'h0, 32'h200);
        checkDecision("call full", 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'h8, 32'h0, 32'h0, 32'h0);
            checkDecision("ret", 1'b1, 1'b1, 32'h107 - i, 1'b0);
        end
        applyStimulus(4'h8, 32'h0, 32'h0, 32'h0);
        checkDecision("ret empty", 1'b0, 1'b0, 32'h0, 1'b1);

        applyStimulus(4'h0, 32'h0, 32'h0, 32'h0);
        checkDecision("bp first", 1'b1, 1'b0, 32'h0, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 4'h7;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp in_ready",  64'(in_ready),  64'(0));
            checkOutput("bp held valid", 64'(out_valid), 64'(1));
            checkOutput("bp held taken", 64'(out_taken), 64'(1));
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp release in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        checkDecision("bp second", 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("bp drained", 64'(out_valid), 64'(0));

        doReset();
        exp_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int r;
            checkOutput("rnd valid", 64'(out_valid), 64'(exp_valid));
            if (exp_valid) begin
                checkOutput("rnd taken",  64'(out_taken),  64'(exp_taken));
                checkOutput("rnd ret",    64'(out_ret),    64'(exp_ret));
                checkOutput("rnd target", 64'(out_target), 64'(exp_target));
                checkOutput("rnd err",    64'(out_err),    64'(exp_err));
            end
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            r = $urandom_range(9);
            op = (r < 3) ? 4'h9 : (r < 6) ? 4'h8 : 4'($urandom_range(15));
            a = $urandom;
            b = ($urandom_range(3) == 0) ? a : $urandom;
            if (op == 4'hB) b = $urandom_range(47);
            pc_next = $urandom;
            #1;
            checkOutput("rnd in_ready", 64'(in_ready), 64'(!exp_valid || out_ready));
            if (in_valid && (!exp_valid || out_ready)) begin
                modelDecide(op, a, b, pc_next);
                exp_valid = 1'b1;
            end else if (out_ready) begin
                exp_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        doReset();
        irq = 32'h24;
        @(negedge clk);
        irq = '0;
        @(negedge clk);
        checkOutput("prio int_req", 64'(int_req), 64'(1));
        checkOutput("prio int_id",  64'(int_id),  64'(2));
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        checkOutput("prio in_service", 64'(in_service), 64'(1));
        checkOutput("prio req dropped", 64'(int_req), 64'(0));
        applyStimulus(4'hA, 32'h0, 32'h0, 32'h0);
        checkDecision("iret", 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("iret in_service", 64'(in_service), 64'(0));
        @(negedge clk);
        checkOutput("prio next int_req", 64'(int_req), 64'(1));
        checkOutput("prio next int_id",  64'(int_id),  64'(5));

        doReset();
        mask_we    = 1'b1;
        mask_wdata = ~32'h80;
        @(negedge clk);
        mask_we = 1'b0;
        applyStimulus(4'hB, 32'h0, 32'd7, 32'h0);
        checkDecision("soft int", 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("masked int_req", 64'(int_req), 64'(0));
        mask_we    = 1'b1;
        mask_wdata = '1;
        @(negedge clk);
        mask_we = 1'b0;
        @(negedge clk);
        checkOutput("unmasked int_req", 64'(int_req), 64'(1));
        checkOutput("unmasked int_id",  64'(int_id),  64'(7));
        applyStimulus(4'hB, 32'h0, 32'd40, 32'h0);
        checkDecision("bad int", 1'b0, 1'b0, 32'h0, 1'b1);

        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'h9, 32'h0, 32'h0, 32'h300 + i);
            checkDecision("pre-reset call", 1'b1, 1'b0, 32'h0, 1'b0);
        end
        irq = 32'h8;
        @(negedge clk);
        irq = '0;
        @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        checkOutput("pre-reset in_service", 64'(in_service), 64'(1));
        in_valid  = 1'b1;
        op        = 4'h0;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("pre-reset out_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid-reset out_valid",  64'(out_valid),  64'(0));
        checkOutput("mid-reset in_service", 64'(in_service), 64'(0));
        checkOutput("mid-reset int_req",    64'(int_req),    64'(0));
        applyStimulus(4'h8, 32'h0, 32'h0, 32'h0);
        checkDecision("ret after reset", 1'b0, 1'b0, 32'h0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Parametrised successor to the SG32 branch-condition stage.
- Evaluates the full compare set: equal/not-equal, unsigned and signed ordering.
- Owns a hardware call/return stack and a maskable interrupt pending/service controller.
- Sits between decode and fetch. Issues one registered taken/target decision per accepted op through a valid/ready handshake.

Parameters:
- DATA_W, 32, compare operand width.
- ADDR_W, 32, return-address width.
- STACK_DEPTH, 8, call stack entries (power of two, >=2).
- NUM_INT, 32, interrupt lines (<= 2^DATA_W).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  op present.
- in_ready  out  1  unit can accept op.
- op  in  4  condition/control opcode.
- a  in  DATA_W  operand A.
- b  in  DATA_W  operand B; interrupt number for op 0xB.
- pc_next  in  ADDR_W  return address pushed by call.
- out_valid  out  1  decision valid.
- out_ready  in  1  consumer takes decision.
- out_taken  out  1  branch/control transfer taken.
- out_ret  out  1  out_target is a popped return address (ret).
- out_target  out  ADDR_W  popped return address (ret), else 0.
- out_err  out  1  decision carries stack overflow/underflow/bad-int/bad-iret error.
- irq  in  NUM_INT  level hardware interrupt lines.
- mask_we  in  1  write interrupt mask.
- mask_wdata  in  NUM_INT  new mask (1 = enabled).
- int_req  out  1  enabled interrupt pending and not in service.
- int_id  out  $clog2(NUM_INT)  lowest-index enabled pending line.
- int_ack  in  1  control accepts int_req.
- in_service  out  1  interrupt handler active.

Behaviour:
- Reset values (rst_n low at clk edge, overrides everything):
  - out_valid=0, out_taken=0, out_ret=0, out_target=0, out_err=0.
  - Stack pointer=0, pending=0, mask=all 1s.
  - State IDLE: int_req=0, in_service=0.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Op accepted when in_valid && in_ready. Decision registered, appears on out_valid the next cycle (latency 1).
  - Decision held stable until out_valid && out_ready.
  - Back-to-back ops give one decision per cycle with out_ready=1.
- Opcode decode (taken value):
  - 0 always 1; 1 a==b; 2 a!=b; 7 always 0.
  - Unsigned: 3 a>b; 4 a<b; 5 a>=b; 6 a<=b.
  - Signed (two's complement): C a>b; D a<b; E a>=b; F a<=b.
- Call (9):
  - Stack not full: push pc_next, taken=1.
  - Full: no push, taken=0, out_err=1.
- Ret (8):
  - Stack not empty: pop, out_target=top, out_ret=1, taken=1.
  - Empty: taken=0, out_err=1, out_target=0.
- Stack: pointer counts 0..STACK_DEPTH; full when pointer==STACK_DEPTH. Pointer never wraps.
- Int (B):
  - b<NUM_INT: sets pending[b], taken=1.
  - Else: taken=0, out_err=1, no pending change.
- Iret (A):
  - in_service=1: clears in_service, taken=1.
  - Else: taken=0, out_err=1.
- Pending register, per cycle, in priority order:
  - Acked bit cleared.
  - Then OR of irq and soft set. Set wins over same-cycle clear.
- Mask: mask_we loads mask_wdata at the edge. Masked lines stay pending.
- Interrupt FSM:
  - IDLE -> REQ when (pending & mask)!=0.
  - REQ: int_req=1, int_id = lowest set index of pending&mask, re-evaluated each cycle.
  - REQ -> IDLE if (pending & mask) becomes 0.
  - REQ -> SERVICE on int_ack: clear pending[int_id].
  - SERVICE: in_service=1, int_req=0, no nesting.
  - SERVICE -> IDLE on accepted iret.
  - int_ack outside REQ ignored.
- Simultaneous events:
  - Iret accepted in the same cycle that pending&mask is nonzero: goes to IDLE; REQ asserts the following cycle.
  - Reset mid-handshake discards the held decision and clears the stack and all interrupt state.

Test Plan:
- Compare sweep: a=0xFFFFFFFF, b=1. Op3 -> taken=1, opC -> taken=0, op4 -> 0, opD -> 1, op1 -> 0, op2 -> 1. Each on out_valid exactly 1 cycle after accept.
- Stack: 8 calls with pc_next=0x100..0x107 -> taken=1 each. 9th call -> taken=0, err=1. 8 rets -> targets 0x107..0x100. 9th ret -> taken=0, err=1, target=0.
- Backpressure: out_ready=0 for 3 cycles after one decision. in_ready=0, held output unchanged, second op not accepted until out_ready=1.
- Interrupt priority: irq[5] and irq[2] high, mask all 1s -> int_req=1, int_id=2. int_ack -> in_service=1, pending[2]=0, int_req=0. Iret -> taken=1. Next cycle int_req=1, int_id=5.
- Soft int and mask: op B with b=7 and mask[7]=0 -> taken=1, pending[7]=1, int_req=0. Write mask[7]=1 -> int_req=1, int_id=7. Op B with b=40 -> taken=0, err=1.
- Reset mid-operation: stack pointer=3, in_service=1, out_valid=1; pulse rst_n low one cycle -> out_valid=0, in_service=0, int_req=0. First ret after reset -> err=1.
